// File: rtl/memc_pkg.sv
// Shared MEMC types and frame geometry.
// Used by the motion search FSM and its SAD datapath.
package memc_pkg;
  localparam int FRAME_W = 64;
  localparam int FRAME_H = 48;
  localparam int BLK     = 8;
  localparam int BLK_PIX = 64;
  localparam int SAD_W   = 14;

  typedef enum logic [2:0] {
    IDLE,
    REQ_CUR,
    RD_CUR,
    NEXT,
    REQ_REF,
    RD_REF,
    CMP,
    OUT
  } state_t;
endpackage

// File: rtl/sad_accum.sv
// Absolute pixel difference folded into a running SAD.
// Clear wins over enable so a new candidate always starts at zero.
module sad_accum
  import memc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [SAD_W-1:0] sum
);
  logic [8:0] diff;
  logic [7:0] mag;

  // 9-bit subtract, then fold the sign into an 8-bit magnitude
  always_comb begin
    diff = {1'b0, a} - {1'b0, b};
    mag  = diff[8] ? (~diff[7:0] + 8'd1) : diff[7:0];
  end

  // running sum; 64 * 255 fits in 14 bits so no saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + {{(SAD_W-8){1'b0}}, mag};
    end
  end
endmodule

// File: rtl/block_motion_search.sv
// Full-search 8x8 block matcher over a +/-SEARCH_R window.
// Fetches the current block once, then every in-frame candidate.
module block_motion_search
  import memc_pkg::*;
#(
  parameter int SEARCH_R = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_block_id,
  output logic        cur_frame,
  output logic [11:0] block_addr,
  output logic [7:0]  block_size,
  output logic        pixel_ready,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel,
  output logic        mv_valid,
  input  logic        mv_ready,
  output logic [3:0]  mv_dx,
  output logic [3:0]  mv_dy,
  output logic [13:0] mv_sad
);
  localparam logic signed [3:0] R_POS = 4'(SEARCH_R);
  localparam logic signed [3:0] R_NEG = -R_POS;
  localparam logic [7:0] R_MAX = 8'(FRAME_H - BLK);
  localparam logic [7:0] C_MAX = 8'(FRAME_W - BLK);
  localparam logic [5:0] N_BLK =
    6'((FRAME_H / BLK) * (FRAME_W / BLK));

  state_t state, state_n;

  logic [5:0]        id_q;
  logic signed [3:0] dy_q, dx_q, dy_n, dx_n;
  logic [5:0]        pix_cnt;
  logic [7:0]        cbuf [BLK_PIX];

  logic [SAD_W-1:0]  best_sad, best_sad_n, acc;
  logic signed [3:0] best_dx, best_dy;
  logic signed [3:0] best_dx_n, best_dy_n;

  logic [7:0] org_r, org_c, cand_r, cand_c;
  logic in_frame, last_cand, wrap_dx;
  logic pix_in, cur_ph, acc_clr, acc_en;

  assign block_size = 8'h88;

  assign org_r  = {2'b00, id_q[5:3], 3'b000};
  assign org_c  = {2'b00, id_q[2:0], 3'b000};
  assign cand_r = org_r + {{4{dy_q[3]}}, dy_q};
  assign cand_c = org_c + {{4{dx_q[3]}}, dx_q};

  assign in_frame = !cand_r[7] && (cand_r <= R_MAX) &&
                    !cand_c[7] && (cand_c <= C_MAX);
  assign wrap_dx   = dx_q == R_POS;
  assign last_cand = wrap_dx && (dy_q == R_POS);

  assign cur_ph = (state == REQ_CUR) || (state == RD_CUR);
  assign pix_in = pixel_valid &&
    (state inside {REQ_CUR, RD_CUR, REQ_REF, RD_REF});

  sad_accum u_sad (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .a     (cbuf[pix_cnt]),
    .b     (pixel),
    .sum   (acc)
  );

  // next state, candidate stepping and best-match tracking
  always_comb begin
    state_n    = state;
    dy_n       = dy_q;
    dx_n       = dx_q;
    best_sad_n = best_sad;
    best_dx_n  = best_dx;
    best_dy_n  = best_dy;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          dy_n       = R_NEG;
          dx_n       = R_NEG;
          best_sad_n = '1;
          best_dx_n  = '0;
          best_dy_n  = '0;
          state_n    = (req_block_id < N_BLK) ? REQ_CUR : OUT;
        end
      end
      REQ_CUR: begin
        if (pixel_valid) state_n = RD_CUR;
      end
      RD_CUR: begin
        if (pixel_valid && pix_cnt == 6'd63) state_n = NEXT;
      end
      NEXT: begin
        if (in_frame) begin
          acc_clr = 1'b1;
          state_n = REQ_REF;
        end else if (last_cand) begin
          state_n = OUT;
        end else begin
          dx_n = wrap_dx ? R_NEG : dx_q + 4'sd1;
          dy_n = wrap_dx ? dy_q + 4'sd1 : dy_q;
        end
      end
      REQ_REF: begin
        acc_en = pixel_valid;
        if (pixel_valid) state_n = RD_REF;
      end
      RD_REF: begin
        acc_en = pixel_valid;
        if (pixel_valid && pix_cnt == 6'd63) state_n = CMP;
      end
      CMP: begin
        if (acc < best_sad) begin
          best_sad_n = acc;
          best_dx_n  = dx_q;
          best_dy_n  = dy_q;
        end
        if (last_cand) begin
          state_n = OUT;
        end else begin
          state_n = NEXT;
          dx_n = wrap_dx ? R_NEG : dx_q + 4'sd1;
          dy_n = wrap_dx ? dy_q + 4'sd1 : dy_q;
        end
      end
      OUT: begin
        if (mv_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, candidate index and best-so-far registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      id_q     <= '0;
      dy_q     <= R_NEG;
      dx_q     <= R_NEG;
      best_sad <= '1;
      best_dx  <= '0;
      best_dy  <= '0;
    end else begin
      state    <= state_n;
      dy_q     <= dy_n;
      dx_q     <= dx_n;
      best_sad <= best_sad_n;
      best_dx  <= best_dx_n;
      best_dy  <= best_dy_n;
      if (state == IDLE && req_valid && req_ready)
        id_q <= req_block_id;
    end
  end

  // pixel index within the current 64-pixel burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
    end else if (state == NEXT || state == IDLE) begin
      pix_cnt <= '0;
    end else if (pix_in) begin
      pix_cnt <= pix_cnt + 6'd1;
    end
  end

  // current-block buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (pix_in && cur_ph) cbuf[pix_cnt] <= pixel;
  end

  // registered outputs, all decoded from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready   <= 1'b0;
      pixel_ready <= 1'b0;
      cur_frame   <= 1'b0;
      block_addr  <= '0;
      mv_valid    <= 1'b0;
      mv_dx       <= '0;
      mv_dy       <= '0;
      mv_sad      <= '0;
    end else begin
      req_ready   <= state_n == IDLE;
      pixel_ready <= (state_n == REQ_CUR) ||
                     (state_n == REQ_REF);
      mv_valid    <= state_n == OUT;
      if (state == IDLE && state_n == REQ_CUR) begin
        cur_frame  <= 1'b1;
        block_addr <= {req_block_id[5:3], 3'b000,
                       req_block_id[2:0], 3'b000};
      end
      if (state == NEXT && state_n == REQ_REF) begin
        cur_frame  <= 1'b0;
        block_addr <= {cand_r[5:0], cand_c[5:0]};
      end
      if (state_n == OUT && state != OUT) begin
        mv_dx  <= best_dx_n;
        mv_dy  <= best_dy_n;
        mv_sad <= best_sad_n;
      end
    end
  end
endmodule

// File: tb/tb_block_motion_search.sv
// Scoreboard bench for block_motion_search with an SRAM
// controller model and a full-search reference in plain loops.
module tb_block_motion_search;
  localparam int R  = 2;
  localparam int FW = 64;
  localparam int FH = 48;

  typedef struct packed {
    logic [3:0]  dx;
    logic [3:0]  dy;
    logic [13:0] sad;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_block_id;
  logic        cur_frame;
  logic [11:0] block_addr;
  logic [7:0]  block_size;
  logic        pixel_ready;
  logic        pixel_valid;
  logic [7:0]  pixel;
  logic        mv_valid;
  logic        mv_ready;
  logic [3:0]  mv_dx;
  logic [3:0]  mv_dy;
  logic [13:0] mv_sad;

  int n_pass;
  int n_chk;
  exp_t exp_q[$];
  logic [12:0] addr_q[$];
  int ncur, nref, exp_ncur, exp_nref;
  int lat_fixed;
  bit gap_en;
  bit ctl_stream, ctl_ref;
  int ctl_idx;
  logic [7:0] cur_m  [FW*FH];
  logic [7:0] prev_m [FW*FH];

  always #5 clk = ~clk;

  block_motion_search #(.SEARCH_R(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_block_id (req_block_id),
    .cur_frame    (cur_frame),
    .block_addr   (block_addr),
    .block_size   (block_size),
    .pixel_ready  (pixel_ready),
    .pixel_valid  (pixel_valid),
    .pixel        (pixel),
    .mv_valid     (mv_valid),
    .mv_ready     (mv_ready),
    .mv_dx        (mv_dx),
    .mv_dy        (mv_dy),
    .mv_sad       (mv_sad)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, expv, $time);
  endtask

  // full search straight from the block-matching definition
  task automatic model(input int id);
    exp_t e;
    int br, bc, r, c, s, a, b, best, bdx, bdy, nr;
    if (id >= 48) begin
      e.dx = 4'd0; e.dy = 4'd0; e.sad = 14'h3FFF;
      exp_q.push_back(e);
      exp_ncur = 0;
      exp_nref = 0;
      return;
    end
    br = (id / 8) * 8;
    bc = (id % 8) * 8;
    addr_q.push_back({1'b1, 6'(br), 6'(bc)});
    best = 'h3FFF; bdx = 0; bdy = 0; nr = 0;
    for (int dy = -R; dy <= R; dy++) begin
      for (int dx = -R; dx <= R; dx++) begin
        r = br + dy;
        c = bc + dx;
        if (r >= 0 && c >= 0 && r <= FH - 8 && c <= FW - 8) begin
          nr++;
          addr_q.push_back({1'b0, 6'(r), 6'(c)});
          s = 0;
          for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
              a = int'(cur_m[(br + y) * FW + bc + x]);
              b = int'(prev_m[(r + y) * FW + c + x]);
              s += (a > b) ? a - b : b - a;
            end
          end
          if (s < best) begin
            best = s; bdx = dx; bdy = dy;
          end
        end
      end
    end
    e.dx = 4'(bdx); e.dy = 4'(bdy); e.sad = 14'(best);
    exp_q.push_back(e);
    exp_ncur = 1;
    exp_nref = nr;
  endtask

  task automatic fill_shift(input int sx, input int sy);
    for (int i = 0; i < FW * FH; i++) cur_m[i] = 8'($urandom);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++)
        prev_m[r * FW + c] =
          cur_m[((r + sy + FH) % FH) * FW + (c + sx + FW) % FW];
  endtask

  task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < FW * FH; i++) begin
      cur_m[i] = a;
      prev_m[i] = b;
    end
  endtask

  task automatic issue(input int id);
    int n;
    ncur = 0;
    nref = 0;
    model(id);
    n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (req_ready !== 1'b1) chk("req_ready_wait", 32'(req_ready), 1);
    req_block_id = 6'(id);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish_req();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(posedge clk); #1; n++;
    end
    chk("result_done", 32'(exp_q.size()), 0);
    chk("n_cur_fetch", 32'(ncur), 32'(exp_ncur));
    chk("n_ref_fetch", 32'(nref), 32'(exp_nref));
    chk("fetch_left", 32'(addr_q.size()), 0);
  endtask

  task automatic run_req(input int id);
    issue(id);
    finish_req();
  endtask

  // SRAM controller: one burst per request seen while idle
  initial begin : ctl
    logic fr;
    logic [11:0] ad;
    logic [12:0] ea;
    logic hold_ok, stab_ok;
    int l, i, pa;
    pixel_valid = 1'b0;
    pixel = '0;
    ctl_stream = 1'b0;
    ctl_ref = 1'b0;
    ctl_idx = 0;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && pixel_ready === 1'b1) begin
        fr = cur_frame;
        ad = block_addr;
        if (fr) ncur++; else nref++;
        if (addr_q.size() == 0) begin
          chk("fetch_extra", {19'b0, fr, ad}, 32'hFFFFFFFF);
        end else begin
          ea = addr_q.pop_front();
          chk("fetch_addr", {19'b0, fr, ad}, {19'b0, ea});
        end
        chk("fetch_size", 32'(block_size), 32'h88);
        l = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
        hold_ok = 1'b1;
        for (int k = 0; k < l && rst_n; k++) begin
          @(posedge clk); #1;
          if (rst_n && pixel_ready !== 1'b1) hold_ok = 1'b0;
        end
        if (l > 0 && rst_n) chk("preq_hold", 32'(hold_ok), 1);
        stab_ok = 1'b1;
        i = 0;
        ctl_stream = 1'b1;
        ctl_ref = !fr;
        while (i < 64 && rst_n) begin
          if (gap_en && $urandom_range(0, 7) == 0) begin
            pixel_valid = 1'b0;
          end else begin
            pa = (int'(ad[11:6]) + i / 8) * FW + int'(ad[5:0]) + i % 8;
            pixel_valid = 1'b1;
            pixel = fr ? cur_m[pa] : prev_m[pa];
            i++;
          end
          ctl_idx = i;
          @(posedge clk); #1;
          if (rst_n && i == 1 && pixel_valid)
            chk("preq_drop", 32'(pixel_ready), 0);
          if (rst_n && (cur_frame !== fr || block_addr !== ad))
            stab_ok = 1'b0;
        end
        pixel_valid = 1'b0;
        ctl_stream = 1'b0;
        if (rst_n) chk("addr_stable", 32'(stab_ok), 1);
      end
    end
  end

  // result monitor: pops one expectation per accepted result
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (rst_n === 1'b1 && mv_valid === 1'b1 && mv_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("mv_extra", {10'b0, mv_dx, mv_dy, mv_sad}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("mv_dx", 32'(mv_dx), 32'(e.dx));
          chk("mv_dy", 32'(mv_dy), 32'(e.dy));
          chk("mv_sad", 32'(mv_sad), 32'(e.sad));
        end
      end
    end
  end

  initial begin : stim
    int n;
    logic ok_s, ok_r;
    logic [21:0] snap;
    n_pass = 0;
    n_chk = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_block_id = '0;
    mv_ready = 1'b1;
    lat_fixed = -1;
    gap_en = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_pixel_ready", 32'(pixel_ready), 0);
    chk("rst_cur_frame", 32'(cur_frame), 0);
    chk("rst_block_addr", 32'(block_addr), 0);
    chk("rst_block_size", 32'(block_size), 32'h88);
    chk("rst_mv_valid", 32'(mv_valid), 0);
    chk("rst_mv", {10'b0, mv_dx, mv_dy, mv_sad}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rdy_reset_cycle", 32'(req_ready), 0);
    @(posedge clk); #1;
    chk("rdy_idle", 32'(req_ready), 1);

    fill_shift(1, 0);
    lat_fixed = 2;
    run_req(9);

    fill_shift(0, 0);
    run_req(0);

    fill_const(8'h10, 8'h20);
    run_req(47);

    fill_shift(-1, 1);
    lat_fixed = 20;
    run_req(20);
    lat_fixed = -1;

    fill_shift(2, -1);
    mv_ready = 1'b0;
    issue(13);
    n = 0;
    while (mv_valid !== 1'b1 && n < 6000) begin
      @(posedge clk); #1; n++;
    end
    chk("hold_reached", 32'(mv_valid), 1);
    snap = {mv_dx, mv_dy, mv_sad};
    ok_s = 1'b1;
    ok_r = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if ({mv_valid, mv_dx, mv_dy, mv_sad} !== {1'b1, snap}) ok_s = 1'b0;
      if (req_ready !== 1'b0) ok_r = 1'b0;
    end
    chk("hold_stable", 32'(ok_s), 1);
    chk("hold_req_ready", 32'(ok_r), 1);
    mv_ready = 1'b1;
    finish_req();

    run_req(48);

    fill_shift(1, 1);
    issue(27);
    n = 0;
    while (!(ctl_stream && ctl_ref && ctl_idx > 20) && n < 6000) begin
      @(posedge clk); #1; n++;
    end
    chk("rd_ref_reached", 32'(ctl_stream && ctl_ref), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 0);
    chk("arst_pixel_ready", 32'(pixel_ready), 0);
    chk("arst_block_addr", 32'(block_addr), 0);
    chk("arst_cur_frame", 32'(cur_frame), 0);
    chk("arst_mv_valid", 32'(mv_valid), 0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_req(27);

    gap_en = 1'b1;
    for (int t = 0; t < 6; t++) begin
      fill_shift($urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3);
      run_req(int'($urandom_range(0, 52)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
